// File: rtl/apple1_reset_pkg.sv
// Shared types and default timing constants for the apple1 board reset sequencer.
// Latency: none (package only).
// Backpressure: none (package only).
// Contents: state_t (3-bit state encoding for state_dbg), default cycle
// counts at 25 MHz, and a small max helper used to size the shared counter.
package apple1_reset_pkg;

  typedef enum logic [2:0] {
    S_POR      = 3'd0,
    S_BOOT_CLS = 3'd1,
    S_RUN      = 3'd2,
    S_CLS      = 3'd3,
    S_BTN_RST  = 3'd4
  } state_t;

  localparam int POR_CYCLES_DEF       = 1000000; // 40 ms
  localparam int DEBOUNCE_CYCLES_DEF  = 250000;  // 10 ms
  localparam int MIN_RESET_CYCLES_DEF = 1024;
  localparam int CLS_CYCLES_DEF       = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchroniser plus debounce counter for one active-low button.
// Latency: a steady level change appears on level_n DEBOUNCE_CYCLES+2 edges after first sample.
// Backpressure: none; free-running, always accepts the raw input.
// Ports: clk25 (clock), rst (sync active-high reset), btn_n (raw async
// button), level_n (debounced level, resets to 1 = released).
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk25,
  input  logic rst,
  input  logic btn_n,
  output logic level_n
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk25) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level_n <= 1'b1;
      cnt     <= '0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      // Any sample agreeing with the current level restarts the stability
      // window, so only an unbroken run of DEBOUNCE_CYCLES differing samples
      // can move the output.
      if (sync2 == level_n) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level_n <= sync2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset / clear-screen sequencer: POR hold, min-width button reset, timed cls pulses.
// Latency: button reset reaches sys_rst_n DEBOUNCE_CYCLES+3 edges after first low sample.
// Backpressure: none; button presses outside S_RUN/S_CLS are dropped, never queued.
// Ports: clk25, rst (sync active-high), btn_reset_n / btn_cls_n (raw async
// buttons), sys_rst_n (apple1 rst_n), cls (apple1 vga_cls), state_dbg (LEDs).
// Build option: define RESET_SEQ_BOOT_CLS_EN to issue a cls pulse after every
// reset release (S_BOOT_CLS); without it resets release straight into S_RUN.
module reset_sequencer
  import apple1_reset_pkg::*;
#(
  parameter int POR_CYCLES       = POR_CYCLES_DEF,
  parameter int DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
  parameter int MIN_RESET_CYCLES = MIN_RESET_CYCLES_DEF,
  parameter int CLS_CYCLES       = CLS_CYCLES_DEF
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       btn_reset_n,
  input  logic       btn_cls_n,
  output logic       sys_rst_n,
  output logic       cls,
  output logic [2:0] state_dbg
);

  localparam int CNT_MAX = max_int(max_int(POR_CYCLES, MIN_RESET_CYCLES), CLS_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLS_LAST = CNT_W'(CLS_CYCLES - 1);

`ifdef RESET_SEQ_BOOT_CLS_EN
  localparam state_t AFTER_RESET = S_BOOT_CLS;
`else
  localparam state_t AFTER_RESET = S_RUN;
`endif

  logic             rst_lvl_n;
  logic             cls_lvl_n;
  logic             cls_lvl_prev_n;
  logic             cls_fall;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_reset (
    .clk25   (clk25),
    .rst     (rst),
    .btn_n   (btn_reset_n),
    .level_n (rst_lvl_n)
  );

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_cls (
    .clk25   (clk25),
    .rst     (rst),
    .btn_n   (btn_cls_n),
    .level_n (cls_lvl_n)
  );

  // Edge, not level: a held button yields one pulse, and a button already
  // held when S_RUN is entered has no fresh edge to act on.
  assign cls_fall = cls_lvl_prev_n & ~cls_lvl_n;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    case (state)
      S_POR: begin
        if (cnt == POR_LAST) state_nxt = AFTER_RESET;
      end
`ifdef RESET_SEQ_BOOT_CLS_EN
      S_BOOT_CLS: begin
        if (!rst_lvl_n)           state_nxt = S_BTN_RST;
        else if (cnt == CLS_LAST) state_nxt = S_RUN;
      end
`endif
      S_RUN: begin
        cnt_nxt = '0;
        if (!rst_lvl_n)    state_nxt = S_BTN_RST;
        else if (cls_fall) state_nxt = S_CLS;
      end
      S_CLS: begin
        if (!rst_lvl_n)           state_nxt = S_BTN_RST;
        else if (cnt == CLS_LAST) state_nxt = S_RUN;
      end
      S_BTN_RST: begin
        // Saturate so a long press cannot wrap the counter and cut the
        // minimum width short after release.
        if (cnt >= MIN_LAST) begin
          cnt_nxt = cnt;
          if (rst_lvl_n) state_nxt = AFTER_RESET;
        end
      end
      default: state_nxt = S_POR;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register and are driven straight from flops.
  always_ff @(posedge clk25) begin
    if (rst) begin
      state          <= S_POR;
      cnt            <= '0;
      cls_lvl_prev_n <= 1'b1;
      sys_rst_n      <= 1'b0;
      cls            <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      cls_lvl_prev_n <= cls_lvl_n;
      sys_rst_n      <= !((state_nxt == S_POR) || (state_nxt == S_BTN_RST));
      cls            <= (state_nxt == S_CLS) || (state_nxt == S_BOOT_CLS);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: directed scenarios plus random button traffic
// compared every cycle against a history-based reference model.
module tb_reset_sequencer;

  localparam int POR = 20;
  localparam int DEB = 8;
  localparam int MINR = 16;
  localparam int CLSN = 4;
  localparam int MAXC = 8192;
`ifdef RESET_SEQ_BOOT_CLS_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  logic       clk25 = 1'b0;
  logic       rst = 1'b1;
  logic       btn_reset_n = 1'b1;
  logic       btn_cls_n = 1'b1;
  logic       sys_rst_n;
  logic       cls;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  always #20 clk25 = ~clk25;

  reset_sequencer #(
    .POR_CYCLES(POR), .DEBOUNCE_CYCLES(DEB),
    .MIN_RESET_CYCLES(MINR), .CLS_CYCLES(CLSN)
  ) dut (
    .clk25(clk25), .rst(rst), .btn_reset_n(btn_reset_n), .btn_cls_n(btn_cls_n),
    .sys_rst_n(sys_rst_n), .cls(cls), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw samples are kept per edge; a debounced level flips once the last DEB
  // synchronised samples (raw delayed two edges) all disagree with it.
  bit hr[MAXC];
  bit hc[MAXC];
  bit hrst[MAXC];
  int edge_n = 0;
  int last_rst = 0;
  int mode = 0;     // expected state_dbg code
  int entry = 0;    // edge at which the current mode was entered
  bit mdr = 1'b1, mdc = 1'b1, mdc_prev = 1'b1;

  function automatic bit synced(input bit which, input int m);
    if (m < 2) return 1'b1;
    if (hrst[m-1] || hrst[m-2]) return 1'b1;
    return which ? hc[m-2] : hr[m-2];
  endfunction

  function automatic bit flips(input bit which, input bit lvl, input int n);
    if (n - DEB + 1 <= last_rst) return 1'b0;
    for (int k = 0; k < DEB; k++)
      if (synced(which, n - k) == lvl) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int after_reset();
    return BOOT_EN ? 1 : 2;
  endfunction

  function automatic void model_edge();
    int age;
    int nm;
    edge_n++;
    hr[edge_n] = btn_reset_n;
    hc[edge_n] = btn_cls_n;
    hrst[edge_n] = rst;
    if (rst) begin
      mode = 0; entry = edge_n; last_rst = edge_n;
      mdr = 1'b1; mdc = 1'b1; mdc_prev = 1'b1;
    end else begin
      age = edge_n - entry;
      nm = mode;
      case (mode)
        0: if (age >= POR) nm = after_reset();
        1: if (!mdr) nm = 4; else if (age >= CLSN) nm = 2;
        2: if (!mdr) nm = 4; else if (mdc_prev && !mdc) nm = 3;
        3: if (!mdr) nm = 4; else if (age >= CLSN) nm = 2;
        default: if (age >= MINR && mdr) nm = after_reset();
      endcase
      if (nm != mode) begin mode = nm; entry = edge_n; end
      mdc_prev = mdc;
      if (flips(1'b0, mdr, edge_n)) mdr = !mdr;
      if (flips(1'b1, mdc, edge_n)) mdc = !mdc;
    end
  endfunction

  // ---------------- cycle driver ----------------
  int cls_hi = 0, cls_rise = 0;
  logic cls_seen = 1'b0;

  task automatic cyc();
    if (edge_n >= MAXC - 2) begin
      $display("FAIL cycle_budget: got %0d, expected below %0d", edge_n, MAXC - 2);
      $fatal(1, "cycle budget exhausted");
    end
    @(posedge clk25);
    model_edge();
    @(negedge clk25);
    check("sys_rst_n", int'(sys_rst_n), int'(!(mode == 0 || mode == 4)));
    check("cls", int'(cls), int'(mode == 1 || mode == 3));
    check("state_dbg", int'(state_dbg), mode);
    if (cls === 1'b1) cls_hi++;
    if (cls === 1'b1 && cls_seen !== 1'b1) cls_rise++;
    cls_seen = cls;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clr_cnt();
    cls_hi = 0; cls_rise = 0;
  endtask

  int lat;
  int low_cnt;
  int seg;

  initial begin
    @(negedge clk25);
    // Reset and power-on hold
    rst = 1'b1;
    run(3);
    check("reset_state", int'(state_dbg), 0);
    check("reset_sys_rst_n", int'(sys_rst_n), 0);
    rst = 1'b0;
    clr_cnt();
    run(30);
    check("boot_cls_len", cls_hi, BOOT_EN ? CLSN : 0);
    check("run_state", int'(state_dbg), 2);

    // Short reset glitch is filtered
    btn_reset_n = 1'b0; run(5);
    btn_reset_n = 1'b1; run(20);
    check("glitch_filtered", int'(state_dbg), 2);

    // Held reset press: latency to sys_rst_n
    btn_reset_n = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (lat == 0 && sys_rst_n === 1'b0) lat = k;
    end
    check("rst_latency", lat, DEB + 3);
    btn_reset_n = 1'b1; run(40);

    // Short press: low time set by min width / release debounce
    btn_reset_n = 1'b0; run(10);
    btn_reset_n = 1'b1; run(50);

    // Held cls button: one pulse; second press another
    clr_cnt();
    btn_cls_n = 1'b0; run(100);
    check("held_cls_pulses", cls_rise, 1);
    check("held_cls_width", cls_hi, CLSN);
    btn_cls_n = 1'b1; run(20);
    clr_cnt();
    btn_cls_n = 1'b0; run(20);
    check("second_cls_pulses", cls_rise, 1);
    btn_cls_n = 1'b1; run(20);

    // Reset debounced during second cycle of S_CLS aborts the pulse
    clr_cnt();
    btn_cls_n = 1'b0; run(2);
    btn_reset_n = 1'b0; run(15);
    check("abort_cls_len", cls_hi, 2);
    btn_cls_n = 1'b1; btn_reset_n = 1'b1; run(60);

    // Both buttons debounced together: reset wins, no cls
    clr_cnt();
    btn_cls_n = 1'b0; btn_reset_n = 1'b0; run(40);
    check("both_no_cls", cls_hi, 0);
    check("both_state", int'(state_dbg), 4);
    btn_cls_n = 1'b1; btn_reset_n = 1'b1; run(60);

    // rst pulse during S_BTN_RST restarts the full POR hold
    btn_reset_n = 1'b0; run(12);
    check("in_btn_rst", int'(state_dbg), 4);
    rst = 1'b1; btn_reset_n = 1'b1;
    cyc();
    check("rst_abort_state", int'(state_dbg), 0);
    rst = 1'b0;
    low_cnt = 1;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (sys_rst_n === 1'b0) low_cnt++;
    end
    check("por_hold_len", low_cnt, POR);

    // Random traffic
    for (seg = 0; seg < 120; seg++) begin
      rst = ($urandom_range(0, 39) == 0);
      btn_reset_n = ($urandom_range(0, 5) != 0);
      btn_cls_n = ($urandom_range(0, 2) != 0);
      run(rst ? 1 : $urandom_range(1, 30));
    end
    rst = 1'b0; btn_reset_n = 1'b1; btn_cls_n = 1'b1;
    run(60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
